// File: rtl/chip_emulator.sv
// chip_emulator: behavioural 74xx responder for the 14-pin DIP chip checker.
// Ports: Clk/Reset, Enable, Chip_Sel, Fault_Mode/Fault_Gate, Pin_In -> Pin_Out/Pin_OE,
//        Vec_Count, State_O, Unsup.
module chip_emulator #(
   parameter int unsigned DELAY = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Enable,
   input  logic [2:0]       Chip_Sel,
   input  logic [1:0]       Fault_Mode,
   input  logic [2:0]       Fault_Gate,
   input  logic [13:0]      Pin_In,
   output logic [13:0]      Pin_Out,
   output logic [13:0]      Pin_OE,
   output logic [CNT_W-1:0] Vec_Count,
   output logic [1:0]       State_O,
   output logic             Unsup
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_RUN   = 2'd2,
      S_UNSUP = 2'd3
   } state_t;

   localparam logic [2:0] C7400 = 3'd1;
   localparam logic [2:0] C7402 = 3'd2;
   localparam logic [2:0] C7404 = 3'd3;
   localparam logic [2:0] C7410 = 3'd4;
   localparam logic [2:0] C7420 = 3'd5;
   localparam logic [2:0] C7427 = 3'd6;

   localparam logic [1:0] F_SA0 = 2'd1;
   localparam logic [1:0] F_SA1 = 2'd2;
   localparam logic [1:0] F_INV = 2'd3;

   state_t           state_q, state_d;
   logic [2:0]       sel_q;
   logic [13:0]      in_q, in_prev_q;
   logic [1:0]       fm_q;
   logic [2:0]       fg_q;
   logic [3:0]       arm_cnt_q, arm_cnt_d;
   logic [CNT_W-1:0] vec_q, vec_d;
   logic [13:0]      dl_q [DELAY];

   logic [5:0]       g_raw, g_flt;
   logic [2:0]       n_gates;
   logic [13:0]      omask, imask, res_d;
   logic             sel_chg, sel_ok, arm_clr, in_chg, run;

   function automatic logic supported(input logic [2:0] s);
      return (s >= C7400) && (s <= C7427);
   endfunction

   // Gate evaluation and pin masks for the registered chip selection.
   always_comb begin
      g_raw   = '0;
      n_gates = 3'd0;
      omask   = '0;
      imask   = '0;
      case (sel_q)
         C7400: begin
            g_raw[0] = ~(in_q[0] & in_q[1]);
            g_raw[1] = ~(in_q[3] & in_q[4]);
            g_raw[2] = ~(in_q[9] & in_q[8]);
            g_raw[3] = ~(in_q[12] & in_q[11]);
            n_gates  = 3'd4;
            omask    = 14'h04A4;
            imask    = 14'h1B1B;
         end
         C7402: begin
            g_raw[0] = ~(in_q[1] | in_q[2]);
            g_raw[1] = ~(in_q[4] | in_q[5]);
            g_raw[2] = ~(in_q[7] | in_q[8]);
            g_raw[3] = ~(in_q[10] | in_q[11]);
            n_gates  = 3'd4;
            omask    = 14'h1209;
            imask    = 14'h0DB6;
         end
         C7404: begin
            g_raw[0] = ~in_q[0];
            g_raw[1] = ~in_q[2];
            g_raw[2] = ~in_q[4];
            g_raw[3] = ~in_q[8];
            g_raw[4] = ~in_q[10];
            g_raw[5] = ~in_q[12];
            n_gates  = 3'd6;
            omask    = 14'h0AAA;
            imask    = 14'h1515;
         end
         C7410: begin
            g_raw[0] = ~(in_q[0] & in_q[1] & in_q[12]);
            g_raw[1] = ~(in_q[2] & in_q[3] & in_q[4]);
            g_raw[2] = ~(in_q[8] & in_q[9] & in_q[10]);
            n_gates  = 3'd3;
            omask    = 14'h08A0;
            imask    = 14'h171F;
         end
         C7420: begin
            g_raw[0] = ~(in_q[0] & in_q[1] & in_q[3] & in_q[4]);
            g_raw[1] = ~(in_q[8] & in_q[9] & in_q[11] & in_q[12]);
            n_gates  = 3'd2;
            omask    = 14'h00A0;
            imask    = 14'h1B1B;
         end
         C7427: begin
            g_raw[0] = ~(in_q[0] | in_q[1] | in_q[12]);
            g_raw[1] = ~(in_q[2] | in_q[3] | in_q[4]);
            g_raw[2] = ~(in_q[8] | in_q[9] | in_q[10]);
            n_gates  = 3'd3;
            omask    = 14'h08A0;
            imask    = 14'h171F;
         end
         default: ;
      endcase
   end

   // A gate index beyond this chip's gate count leaves all gates untouched.
   always_comb begin
      g_flt = g_raw;
      if (fg_q < n_gates) begin
         case (fm_q)
            F_SA0:   g_flt[fg_q] = 1'b0;
            F_SA1:   g_flt[fg_q] = 1'b1;
            F_INV:   g_flt[fg_q] = ~g_raw[fg_q];
            default: ;
         endcase
      end
   end

   // Place gate outputs on their pins.
   always_comb begin
      res_d = '0;
      case (sel_q)
         C7400, C7402: begin
            if (sel_q == C7400) begin
               res_d[2]  = g_flt[0];
               res_d[5]  = g_flt[1];
               res_d[7]  = g_flt[2];
               res_d[10] = g_flt[3];
            end else begin
               res_d[0]  = g_flt[0];
               res_d[3]  = g_flt[1];
               res_d[9]  = g_flt[2];
               res_d[12] = g_flt[3];
            end
         end
         C7404: begin
            res_d[1]  = g_flt[0];
            res_d[3]  = g_flt[1];
            res_d[5]  = g_flt[2];
            res_d[7]  = g_flt[3];
            res_d[9]  = g_flt[4];
            res_d[11] = g_flt[5];
         end
         C7410, C7427: begin
            res_d[11] = g_flt[0];
            res_d[5]  = g_flt[1];
            res_d[7]  = g_flt[2];
         end
         C7420: begin
            res_d[5] = g_flt[0];
            res_d[7] = g_flt[1];
         end
         default: ;
      endcase
   end

   assign sel_chg = (sel_q != Chip_Sel);
   assign sel_ok  = supported(Chip_Sel);
   assign in_chg  = |((in_q ^ in_prev_q) & imask);

   // Mode sequencing; Enable low wins from any state.
   always_comb begin
      state_d = state_q;
      arm_clr = 1'b0;
      if (!Enable) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE, S_UNSUP: begin
               if (sel_ok) begin
                  state_d = S_ARM;
                  arm_clr = 1'b1;
               end else begin
                  state_d = S_UNSUP;
               end
            end
            S_ARM, S_RUN: begin
               if (sel_chg) begin
                  if (sel_ok) begin
                     state_d = S_ARM;
                     arm_clr = 1'b1;
                  end else begin
                     state_d = S_UNSUP;
                  end
               end else if (state_q == S_ARM && arm_cnt_q == 4'(DELAY)) begin
                  state_d = S_RUN;
               end
            end
         endcase
      end
   end

   always_comb begin
      arm_cnt_d = arm_cnt_q;
      vec_d     = vec_q;
      if (arm_clr) begin
         arm_cnt_d = '0;
         vec_d     = '0;
      end else begin
         if (state_q == S_ARM)
            arm_cnt_d = arm_cnt_q + 4'd1;
         if (state_q == S_RUN && in_chg && vec_q != '1)
            vec_d = vec_q + 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         sel_q     <= '0;
         in_q      <= '0;
         in_prev_q <= '0;
         fm_q      <= '0;
         fg_q      <= '0;
         arm_cnt_q <= '0;
         vec_q     <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= Chip_Sel;
         in_q      <= Pin_In;
         in_prev_q <= in_q;
         fm_q      <= Fault_Mode;
         fg_q      <= Fault_Gate;
         arm_cnt_q <= arm_cnt_d;
         vec_q     <= vec_d;
      end
   end

   // Propagation-delay line.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < int'(DELAY); i++)
            dl_q[i] <= '0;
      end else begin
         dl_q[0] <= res_d;
         for (int i = 1; i < int'(DELAY); i++)
            dl_q[i] <= dl_q[i-1];
      end
   end

   // Outputs decode straight from registers so Reset releases pins at once.
   assign run       = (state_q == S_RUN);
   assign Pin_OE    = run ? omask : '0;
   assign Pin_Out   = run ? (dl_q[DELAY-1] & omask) : '0;
   assign Vec_Count = vec_q;
   assign State_O   = state_q;
   assign Unsup     = (state_q == S_UNSUP);

endmodule
